// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: shared prescaler and period counter, edge- or center-aligned,
// with duty/period/prescale/mode double-buffered and applied only at a period boundary.
//   state   | meaning
//   ST_UP   | counter rising (edge mode always, center mode first half)
//   ST_DOWN | center mode falling half, P_a-1 down to 1
module pwm_multichannel #(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en_out,
    input  logic [NUM_CH-1:0]       en_pwm,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [CNT_W-1:0]        period,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic                    center_mode,
    input  logic                    load,
    output logic [NUM_CH-1:0]       out,
    output logic                    period_start
);
    typedef enum logic {ST_UP = 1'b0, ST_DOWN = 1'b1} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]   duty_a [NUM_CH];
    logic [CNT_W-1:0]   p_a;
    logic [PRESC_W-1:0] s_a;
    logic               mode_a;
    logic               pend;
    logic [PRESC_W-1:0] pcnt;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic               at_top;
    logic               boundary;
    logic               apply;
    logic               cnt_inc;
    logic               cnt_dec;

    assign tick   = (pcnt == s_a);
    assign at_top = (cnt == p_a);
    assign apply  = boundary & (pend | load);

    // Center mode with P_a = 1 never enters ST_DOWN: the rising tick at cnt = 1 already closes the period.
    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (!mode_a)
                boundary = at_top;
            else
                boundary = (p_a == '0) || ((cnt == CNT_W'(1)) && (state == ST_DOWN || at_top));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_UP;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (boundary)
            state_nxt = ST_UP;
        else if (tick && mode_a && state == ST_UP && at_top)
            state_nxt = ST_DOWN;
    end

    always_comb begin
        cnt_inc = 1'b0;
        cnt_dec = 1'b0;
        if (tick && !boundary) begin
            if (state == ST_DOWN || (mode_a && at_top))
                cnt_dec = 1'b1;
            else
                cnt_inc = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            cnt  <= '0;
        end else begin
            if (tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + 1'b1;
            if (boundary)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            else if (cnt_dec)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_a    <= '0;
            s_a    <= '0;
            mode_a <= 1'b0;
            pend   <= 1'b1;
            for (int i = 0; i < NUM_CH; i++)
                duty_a[i] <= '0;
        end else begin
            if (apply) begin
                p_a    <= period;
                s_a    <= prescale;
                mode_a <= center_mode;
                for (int i = 0; i < NUM_CH; i++)
                    duty_a[i] <= duty[i*CNT_W +: CNT_W];
            end
            if (apply)
                pend <= 1'b0;
            else if (load)
                pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            for (int i = 0; i < NUM_CH; i++)
                out[i] <= en_out[i] & (~en_pwm[i] | (cnt < duty_a[i]));
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: a period-position reference model plus
// directed duty/period/pattern checks per feature.
module tb_pwm_multichannel;
    localparam int NUM_CH  = 16;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       en_out;
    logic [NUM_CH-1:0]       en_pwm;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [CNT_W-1:0]        period;
    logic [PRESC_W-1:0]      prescale;
    logic                    center_mode;
    logic                    load;
    logic [NUM_CH-1:0]       out;
    logic                    period_start;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst_n(rst_n), .en_out(en_out), .en_pwm(en_pwm), .duty(duty),
        .period(period), .prescale(prescale), .center_mode(center_mode), .load(load),
        .out(out), .period_start(period_start)
    );

    // Reference model: position k inside the current period; counter value derived arithmetically.
    int m_k, m_p, m_s, m_mode, m_pend, m_len, m_t, m_c;
    int m_duty [NUM_CH];
    logic [NUM_CH-1:0] exp_out;
    logic              exp_ps;

    initial begin
        forever begin
            if (!rst_n) begin
                m_k = 0; m_p = 0; m_s = 0; m_mode = 0; m_pend = 1;
                for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
                exp_out = '0;
                exp_ps  = 1'b0;
            end else begin
                m_len = (m_mode == 0) ? (m_p + 1) * (m_s + 1)
                      : (m_p == 0)    ? (m_s + 1) : 2 * m_p * (m_s + 1);
                m_t = m_k / (m_s + 1);
                m_c = (m_mode == 0 || m_t <= m_p) ? m_t : 2 * m_p - m_t;
                for (int i = 0; i < NUM_CH; i++)
                    exp_out[i] = en_out[i] ? (en_pwm[i] ? (m_c < m_duty[i]) : 1'b1) : 1'b0;
                exp_ps = (m_k == m_len - 1);
                if (exp_ps) begin
                    m_k = 0;
                    if (m_pend != 0 || load) begin
                        m_p = int'(period); m_s = int'(prescale); m_mode = int'(center_mode);
                        for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty[i*CNT_W +: CNT_W]);
                        m_pend = 0;
                    end
                end else begin
                    m_k++;
                    if (load) m_pend = 1;
                end
            end
            @(posedge clk or negedge rst_n);
        end
    end

    task automatic set_duty(input int ch, input int v);
        duty[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic wait_ps(input string tag);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (period_start !== 1'b1 && w < 300);
        if (period_start !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL %s_sync: no period_start within %0d clocks", tag, w);
        end
    endtask

    task automatic test_reset();
        int last = -1;
        int first = -1;
        en_out = '1; en_pwm = '1; period = 9; prescale = 0; center_mode = 0; load = 0;
        for (int i = 0; i < NUM_CH; i++) set_duty(i, $urandom_range(1, 12));
        set_duty(0, 5);
        @(negedge clk);
        n_cmp++;
        if (out !== '0 || period_start !== 1'b0) begin
            n_err++; $display("FAIL reset_powerup: out=%h ps=%b required 0/0", out, period_start);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL reset_run c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out !== '0 || period_start !== 1'b0) begin
            n_err++; $display("FAIL reset_async: out=%h ps=%b required 0/0", out, period_start);
        end
        @(negedge clk);
        n_cmp++;
        if (out !== '0 || period_start !== 1'b0) begin
            n_err++; $display("FAIL reset_hold: out=%h ps=%b required 0/0", out, period_start);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL reset_model c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
            if (period_start === 1'b1) begin
                if (first < 0) first = c;
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 10) begin
                        n_err++; $display("FAIL reset_interval: got %0d clocks required 10", c - last);
                    end
                end
                last = c;
            end
        end
        n_cmp++;
        if (first != 0) begin
            n_err++; $display("FAIL reset_first_ps: at clock %0d required 0", first);
        end
    endtask

    task automatic test_edge_duty();
        int hi0 = 0, hi1 = 0, hi2 = 0;
        period = 9; prescale = 0; center_mode = 0; en_out = '1; en_pwm = '1;
        for (int i = 0; i < NUM_CH; i++) set_duty(i, $urandom_range(0, 12));
        set_duty(0, 3); set_duty(1, 0); set_duty(2, 10);
        load = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            load = 1'b0;
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL edge_model c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
        end
        wait_ps("edge");
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL edge_model2 c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
            hi0 += int'(out[0]); hi1 += int'(out[1]); hi2 += int'(out[2]);
        end
        n_cmp++;
        if (hi0 != 9) begin n_err++; $display("FAIL edge_duty3: high %0d of 30 required 9", hi0); end
        n_cmp++;
        if (hi1 != 0) begin n_err++; $display("FAIL edge_duty0: high %0d of 30 required 0", hi1); end
        n_cmp++;
        if (hi2 != 30) begin n_err++; $display("FAIL edge_duty_full: high %0d of 30 required 30", hi2); end
    endtask

    task automatic test_prescaler();
        int hi = 0, nps = 0, first = -1;
        period = 3; prescale = 4; set_duty(0, 2);
        load = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            load = 1'b0;
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL presc_model c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
        end
        wait_ps("presc");
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL presc_model2 c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
            if (c <= 20) hi += int'(out[0]);
            if (period_start === 1'b1) begin
                nps++;
                if (first < 0) first = c;
            end
        end
        n_cmp++;
        if (first != 20 || nps != 2) begin
            n_err++; $display("FAIL presc_period: first ps at %0d count %0d required 20 and 2", first, nps);
        end
        n_cmp++;
        if (hi != 10) begin n_err++; $display("FAIL presc_high: %0d clocks required 10", hi); end
    endtask

    task automatic test_center();
        logic [7:0] pat = 8'b1000_0011;
        period = 4; prescale = 0; center_mode = 1'b1; set_duty(0, 2);
        load = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            load = 1'b0;
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL center_model c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
        end
        wait_ps("center");
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out[0] !== pat[c % 8] || period_start !== ((c % 8) == 7)) begin
                n_err++; $display("FAIL center_pattern c=%0d: out0=%b ps=%b required %b/%b", c, out[0], period_start, pat[c % 8], ((c % 8) == 7));
            end
        end
    endtask

    task automatic test_glitch_free();
        int hi_a = 0, hi_b = 0, hi_c = 0;
        period = 9; prescale = 0; center_mode = 1'b0; set_duty(0, 3);
        load = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            load = 1'b0;
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL glitch_model c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
        end
        wait_ps("glitch");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== exp_out || period_start !== ((c == 9) || (c == 19))) begin
                n_err++; $display("FAIL glitch_update c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, ((c == 9) || (c == 19)));
            end
            if (c < 10) hi_a += int'(out[0]); else hi_b += int'(out[0]);
            load = (c == 3);
            if (c == 3) set_duty(0, 7);
        end
        n_cmp++;
        if (hi_a != 3 || hi_b != 7) begin
            n_err++; $display("FAIL glitch_duty: old period %0d new period %0d required 3 and 7", hi_a, hi_b);
        end
        set_duty(0, 1);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== exp_out || period_start !== exp_ps) begin
                n_err++; $display("FAIL noload_model c=%0d: out=%h ps=%b required %h/%b", c, out, period_start, exp_out, exp_ps);
            end
        end
        wait_ps("noload");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            hi_c += int'(out[0]);
        end
        n_cmp++;
        if (hi_c != 7) begin n_err++; $display("FAIL noload_duty: high %0d required 7", hi_c); end
    endtask

    task automatic test_enables();
        en_out[5] = 1'b1; en_pwm[5] = 1'b0; set_duty(5, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out[5] !== 1'b1 || out !== exp_out) begin
                n_err++; $display("FAIL en_static c=%0d: out=%h required %h with bit5=1", c, out, exp_out);
            end
        end
        repeat ($urandom_range(0, 7)) @(negedge clk);
        en_out[5] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out[5] !== 1'b0) begin n_err++; $display("FAIL en_off: out5=%b required 0", out[5]); end
    endtask

    task automatic test_random();
        int p, lc;
        for (int it = 0; it < 6; it++) begin
            p = (it == 0) ? 0 : (it == 1) ? 1 : $urandom_range(0, 15);
            period = CNT_W'(p);
            prescale = PRESC_W'($urandom_range(0, 3));
            center_mode = (it < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            en_out = NUM_CH'($urandom); en_pwm = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) set_duty(i, $urandom_range(0, p + 2));
            lc = $urandom_range(1, 20);
            for (int c = 0; c < 190; c++) begin
                @(negedge clk);
                n_cmp++;
                if (out !== exp_out || period_start !== exp_ps) begin
                    n_err++; $display("FAIL random it=%0d c=%0d: out=%h ps=%b required %h/%b", it, c, out, period_start, exp_out, exp_ps);
                end
                load = (c == 0) || (c == lc);
                if (c == lc || c == 160)
                    for (int i = 0; i < NUM_CH; i++) set_duty(i, $urandom_range(0, p + 2));
                if (c == 170) en_out = NUM_CH'($urandom);
            end
            load = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        en_out = '0; en_pwm = '0; duty = '0; period = '0; prescale = '0;
        center_mode = 1'b0; load = 1'b0;
        test_reset();
        test_edge_duty();
        test_prescaler();
        test_center();
        test_glitch_free();
        test_enables();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
